// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - PC operation encodings and default reset/exception vectors
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ      = 3'd0,
        PC_BRANCH   = 3'd1,
        PC_JUMP     = 3'd2,
        PC_JUMP_REG = 3'd3,
        PC_CALL     = 3'd4,
        PC_CALL_REG = 3'd5,
        PC_RETURN   = 3'd6,
        PC_ERET     = 3'd7
    } pc_op_t;

    localparam logic [31:0] DEFAULT_START_ADRS = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_EXCP_ADRS  = 32'h0000_0080;

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack; a push when full overwrites the oldest entry
module ras_stack #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4,
    localparam int PW       = $clog2(RAS_DEPTH),
    localparam int CW       = PW + 1
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic [CW-1:0]   count,
    output logic            empty,
    output logic            full
);

    logic [XLEN-1:0] entries [RAS_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   top_ptr;

    // wr_ptr always names the slot after the top, which is also the oldest slot once full
    assign top_ptr = wr_ptr - PW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CW'(RAS_DEPTH));
    assign top     = empty ? '0 : entries[top_ptr];

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                entries[i] <= '0;
            end
            wr_ptr <= '0;
            count  <= '0;
        end else if (push) begin
            entries[wr_ptr] <= push_data;
            wr_ptr          <= wr_ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (pop && !empty) begin
            wr_ptr <= top_ptr;
            count  <= count - CW'(1);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with exception vectoring and return-address prediction
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              RAS_DEPTH  = 4,
    parameter logic [XLEN-1:0] START_ADRS = XLEN'(DEFAULT_START_ADRS),
    parameter logic [XLEN-1:0] EXCP_ADRS  = XLEN'(DEFAULT_EXCP_ADRS)
) (
    input  logic            clk_cpu,
    input  logic            reset,
    input  logic            stall,
    input  pc_op_t          pc_op,
    input  logic            cond,
    input  logic [15:0]     imm16,
    input  logic [25:0]     jaddr,
    input  logic [XLEN-1:0] reg_target,
    input  logic            excp,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] epc,
    output logic [XLEN-1:0] link_addr,
    output logic [XLEN-1:0] ras_top,
    output logic            ras_mispredict,
    output logic            ras_empty,
    output logic            ras_full
);

    localparam int CW = $clog2(RAS_DEPTH) + 1;

    logic [XLEN-1:0] next_pc;
    logic [XLEN-1:0] branch_target;
    logic [XLEN-1:0] jump_target;
    logic            reg_op;
    logic            take_excp;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] epc_d;
    logic            push;
    logic            pop;
    logic            mispredict_d;
    logic            mispredict_q;
    logic [CW-1:0]   ras_count;

    assign next_pc       = pc + XLEN'(4);
    assign branch_target = next_pc + {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
    assign jump_target   = {pc[XLEN-1:28], jaddr, 2'b00};
    assign link_addr     = next_pc;

    // A misaligned register target vectors like an external exception and outranks stall
    assign reg_op    = (pc_op == PC_JUMP_REG) || (pc_op == PC_CALL_REG) || (pc_op == PC_RETURN);
    assign take_excp = excp || (reg_op && (reg_target[1:0] != 2'b00));

    always_comb begin
        pc_d         = pc;
        epc_d        = epc;
        push         = 1'b0;
        pop          = 1'b0;
        mispredict_d = 1'b0;
        if (take_excp) begin
            epc_d = pc;
            pc_d  = EXCP_ADRS;
        end else if (!stall) begin
            case (pc_op)
                PC_SEQ:      pc_d = next_pc;
                PC_BRANCH:   pc_d = cond ? branch_target : next_pc;
                PC_JUMP:     pc_d = jump_target;
                PC_JUMP_REG: pc_d = reg_target;
                PC_CALL: begin
                    pc_d = jump_target;
                    push = 1'b1;
                end
                PC_CALL_REG: begin
                    pc_d = reg_target;
                    push = 1'b1;
                end
                PC_RETURN: begin
                    pc_d         = reg_target;
                    pop          = 1'b1;
                    mispredict_d = ras_empty || (ras_top != reg_target);
                end
                PC_ERET:     pc_d = epc;
                default:     pc_d = next_pc;
            endcase
        end
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            pc           <= START_ADRS;
            epc          <= '0;
            mispredict_q <= 1'b0;
        end else begin
            pc           <= pc_d;
            epc          <= epc_d;
            mispredict_q <= mispredict_d;
        end
    end

    // The pulse is masked during a stalled cycle so a held pipeline never sees it
    assign ras_mispredict = mispredict_q && !stall;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras_stack (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (next_pc),
        .top       (ras_top),
        .count     (ras_count),
        .empty     (ras_empty),
        .full      (ras_full)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;
    import pc_pkg::*;

    logic        clk_cpu;
    logic        reset;
    logic        stall;
    pc_op_t      pc_op;
    logic        cond;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] reg_target;
    logic        excp;
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] link_addr;
    logic [31:0] ras_top;
    logic        ras_mispredict;
    logic        ras_empty;
    logic        ras_full;

    int passed = 0;
    int total  = 0;

    pc_sequencer dut (
        .clk_cpu        (clk_cpu),
        .reset          (reset),
        .stall          (stall),
        .pc_op          (pc_op),
        .cond           (cond),
        .imm16          (imm16),
        .jaddr          (jaddr),
        .reg_target     (reg_target),
        .excp           (excp),
        .pc             (pc),
        .epc            (epc),
        .link_addr      (link_addr),
        .ras_top        (ras_top),
        .ras_mispredict (ras_mispredict),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full)
    );

    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic apply(input pc_op_t op, input logic c, input logic [15:0] imm,
                         input logic [25:0] ja, input logic [31:0] rt,
                         input logic ex, input logic st);
        pc_op      = op;
        cond       = c;
        imm16      = imm;
        jaddr      = ja;
        reg_target = rt;
        excp       = ex;
        stall      = st;
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h0) $display("FAIL reset_pc: got %h want %h", pc, 32'h0); else passed++;
        total++; if (epc !== 32'h0) $display("FAIL reset_epc: got %h want %h", epc, 32'h0); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", ras_empty); else passed++;
        total++; if (ras_full !== 1'b0) $display("FAIL reset_full: got %b want 0", ras_full); else passed++;
        total++; if (ras_mispredict !== 1'b0) $display("FAIL reset_mispredict: got %b want 0", ras_mispredict); else passed++;
        total++; if (ras_top !== 32'h0) $display("FAIL reset_top: got %h want %h", ras_top, 32'h0); else passed++;
        total++; if (link_addr !== 32'h4) $display("FAIL reset_link: got %h want %h", link_addr, 32'h4); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'h4;
        exp_pc[1] = 32'h8;
        exp_pc[2] = 32'hC;
        total++; if (pc !== 32'h0) $display("FAIL seq0: got %h want %h", pc, 32'h0); else passed++;
        for (int i = 0; i < 3; i++) begin
            apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
            total++; if (pc !== exp_pc[i]) $display("FAIL seq%0d: got %h want %h", i + 1, pc, exp_pc[i]); else passed++;
        end
    endtask

    task automatic test_branch();
        apply(PC_JUMP, 1'b0, 16'h0, 26'h40, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h100) $display("FAIL jump_100: got %h want %h", pc, 32'h100); else passed++;
        apply(PC_BRANCH, 1'b1, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h100) $display("FAIL branch_back: got %h want %h", pc, 32'h100); else passed++;
        apply(PC_BRANCH, 1'b0, 16'hFFFF, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h104) $display("FAIL branch_not_taken: got %h want %h", pc, 32'h104); else passed++;
        apply(PC_BRANCH, 1'b1, 16'h0003, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h114) $display("FAIL branch_fwd: got %h want %h", pc, 32'h114); else passed++;
    endtask

    task automatic test_call_return();
        apply(PC_JUMP, 1'b0, 16'h0, 26'h80, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h200) $display("FAIL jump_200: got %h want %h", pc, 32'h200); else passed++;
        apply(PC_CALL, 1'b0, 16'h0, 26'h40, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h100) $display("FAIL call_pc: got %h want %h", pc, 32'h100); else passed++;
        total++; if (ras_top !== 32'h204) $display("FAIL call_top: got %h want %h", ras_top, 32'h204); else passed++;
        total++; if (ras_empty !== 1'b0) $display("FAIL call_empty: got %b want 0", ras_empty); else passed++;
        apply(PC_RETURN, 1'b0, 16'h0, 26'h0, 32'h204, 1'b0, 1'b0);
        total++; if (pc !== 32'h204) $display("FAIL ret_pc: got %h want %h", pc, 32'h204); else passed++;
        total++; if (ras_mispredict !== 1'b0) $display("FAIL ret_mispredict: got %b want 0", ras_mispredict); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL ret_empty: got %b want 1", ras_empty); else passed++;
        total++; if (link_addr !== 32'h208) $display("FAIL ret_link: got %h want %h", link_addr, 32'h208); else passed++;
    endtask

    task automatic test_ras_overflow();
        logic [25:0] call_ja [5];
        logic [31:0] call_pc [5];
        logic [31:0] ret_rt  [5];
        logic        ret_mp  [5];
        call_ja[0] = 26'h100; call_pc[0] = 32'h400;
        call_ja[1] = 26'h200; call_pc[1] = 32'h800;
        call_ja[2] = 26'h300; call_pc[2] = 32'hC00;
        call_ja[3] = 26'h400; call_pc[3] = 32'h1000;
        call_ja[4] = 26'h500; call_pc[4] = 32'h1400;
        // 0x208 was pushed first and lost to the fifth call
        ret_rt[0] = 32'h1004; ret_mp[0] = 1'b0;
        ret_rt[1] = 32'hC04;  ret_mp[1] = 1'b0;
        ret_rt[2] = 32'h804;  ret_mp[2] = 1'b0;
        ret_rt[3] = 32'h404;  ret_mp[3] = 1'b0;
        ret_rt[4] = 32'h208;  ret_mp[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(PC_CALL, 1'b0, 16'h0, call_ja[i], 32'h0, 1'b0, 1'b0);
            total++; if (pc !== call_pc[i]) $display("FAIL ovf_call%0d_pc: got %h want %h", i, pc, call_pc[i]); else passed++;
        end
        total++; if (ras_full !== 1'b1) $display("FAIL ovf_full: got %b want 1", ras_full); else passed++;
        total++; if (ras_top !== 32'h1004) $display("FAIL ovf_top: got %h want %h", ras_top, 32'h1004); else passed++;
        for (int i = 0; i < 5; i++) begin
            apply(PC_RETURN, 1'b0, 16'h0, 26'h0, ret_rt[i], 1'b0, 1'b0);
            total++; if (ras_mispredict !== ret_mp[i]) $display("FAIL ovf_ret%0d_mispredict: got %b want %b", i, ras_mispredict, ret_mp[i]); else passed++;
            total++; if (pc !== ret_rt[i]) $display("FAIL ovf_ret%0d_pc: got %h want %h", i, pc, ret_rt[i]); else passed++;
        end
        total++; if (ras_empty !== 1'b1) $display("FAIL ovf_empty: got %b want 1", ras_empty); else passed++;
        apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (ras_mispredict !== 1'b0) $display("FAIL ovf_pulse_end: got %b want 0", ras_mispredict); else passed++;
        total++; if (pc !== 32'h20C) $display("FAIL ovf_seq_pc: got %h want %h", pc, 32'h20C); else passed++;
    endtask

    task automatic test_exception();
        apply(PC_JUMP, 1'b0, 16'h0, 26'hC0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h300) $display("FAIL jump_300: got %h want %h", pc, 32'h300); else passed++;
        apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1, 1'b1);
        total++; if (pc !== 32'h80) $display("FAIL excp_pc: got %h want %h", pc, 32'h80); else passed++;
        total++; if (epc !== 32'h300) $display("FAIL excp_epc: got %h want %h", epc, 32'h300); else passed++;
        apply(PC_ERET, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h300) $display("FAIL eret_pc: got %h want %h", pc, 32'h300); else passed++;
    endtask

    task automatic test_misalign_stall();
        apply(PC_JUMP_REG, 1'b0, 16'h0, 26'h0, 32'h402, 1'b0, 1'b0);
        total++; if (pc !== 32'h80) $display("FAIL misalign_pc: got %h want %h", pc, 32'h80); else passed++;
        total++; if (epc !== 32'h300) $display("FAIL misalign_epc: got %h want %h", epc, 32'h300); else passed++;
        for (int i = 0; i < 3; i++) begin
            apply(PC_CALL, 1'b0, 16'h0, 26'h123, 32'h0, 1'b0, 1'b1);
            total++; if (pc !== 32'h80) $display("FAIL stall%0d_pc: got %h want %h", i, pc, 32'h80); else passed++;
        end
        total++; if (ras_empty !== 1'b1) $display("FAIL stall_no_push: got %b want 1", ras_empty); else passed++;
        total++; if (epc !== 32'h300) $display("FAIL stall_epc: got %h want %h", epc, 32'h300); else passed++;
        apply(PC_CALL_REG, 1'b0, 16'h0, 26'h0, 32'h501, 1'b0, 1'b0);
        total++; if (ras_empty !== 1'b1) $display("FAIL misalign_no_push: got %b want 1", ras_empty); else passed++;
    endtask

    task automatic test_back_to_back();
        apply(PC_CALL_REG, 1'b0, 16'h0, 26'h0, 32'h500, 1'b0, 1'b0);
        total++; if (pc !== 32'h500) $display("FAIL callreg_pc: got %h want %h", pc, 32'h500); else passed++;
        total++; if (ras_top !== 32'h84) $display("FAIL callreg_top: got %h want %h", ras_top, 32'h84); else passed++;
        apply(PC_RETURN, 1'b0, 16'h0, 26'h0, 32'h600, 1'b0, 1'b0);
        total++; if (ras_mispredict !== 1'b1) $display("FAIL mismatch_pulse: got %b want 1", ras_mispredict); else passed++;
        total++; if (pc !== 32'h600) $display("FAIL mismatch_pc: got %h want %h", pc, 32'h600); else passed++;
        apply(PC_RETURN, 1'b0, 16'h0, 26'h0, 32'h700, 1'b0, 1'b0);
        total++; if (ras_mispredict !== 1'b1) $display("FAIL empty_ret_pulse: got %b want 1", ras_mispredict); else passed++;
        stall = 1'b1;
        #1;
        total++; if (ras_mispredict !== 1'b0) $display("FAIL stall_masks_pulse: got %b want 0", ras_mispredict); else passed++;
        apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b1);
        total++; if (pc !== 32'h700) $display("FAIL stall_after_ret_pc: got %h want %h", pc, 32'h700); else passed++;
    endtask

    task automatic test_reset_mid_op();
        apply(PC_CALL, 1'b0, 16'h0, 26'h10, 32'h0, 1'b0, 1'b0);
        total++; if (ras_top !== 32'h704) $display("FAIL pre_reset_top: got %h want %h", ras_top, 32'h704); else passed++;
        pc_op = PC_CALL;
        jaddr = 26'h20;
        stall = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        total++; if (pc !== 32'h0) $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL async_reset_empty: got %b want 1", ras_empty); else passed++;
        total++; if (ras_top !== 32'h0) $display("FAIL async_reset_top: got %h want %h", ras_top, 32'h0); else passed++;
        @(posedge clk_cpu);
        #1;
        total++; if (pc !== 32'h0) $display("FAIL reset_hold_pc: got %h want %h", pc, 32'h0); else passed++;
        reset = 1'b0;
        apply(PC_SEQ, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0, 1'b0);
        total++; if (pc !== 32'h4) $display("FAIL post_reset_pc: got %h want %h", pc, 32'h4); else passed++;
        total++; if (ras_empty !== 1'b1) $display("FAIL post_reset_empty: got %b want 1", ras_empty); else passed++;
    endtask

    initial begin
        reset      = 1'b1;
        stall      = 1'b0;
        pc_op      = PC_SEQ;
        cond       = 1'b0;
        imm16      = 16'h0;
        jaddr      = 26'h0;
        reg_target = 32'h0;
        excp       = 1'b0;
        test_reset();
        test_seq();
        test_branch();
        test_call_return();
        test_ras_overflow();
        test_exception();
        test_misalign_stall();
        test_back_to_back();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning address/PC width (>=32).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, meaning return-address-stack entries (power of 2, >=2).
REQ-003 SHALL have parameter START_ADRS, default 0, meaning PC value after reset.
REQ-004 SHALL have parameter EXCP_ADRS, default 'h80, meaning exception vector.
REQ-005 clk_cpu  in  1  CPU clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 stall  in  1  hold PC/state this cycle.
REQ-008 pc_op  in  3  operation class from decode (pc_op_t).
REQ-009 cond  in  1  branch condition true (BRANCH only).
REQ-010 imm16  in  16  branch offset, in words.
REQ-011 jaddr  in  26  jump word address.
REQ-012 reg_target  in  XLEN  register jump target.
REQ-013 excp  in  1  synchronous exception request.
REQ-014 pc  out  XLEN  current PC.
REQ-015 epc  out  XLEN  PC of last excepting instruction.
REQ-016 link_addr  out  XLEN  pc+4, combinational.
REQ-017 ras_top  out  XLEN  predicted return address (top entry; 0 when empty).
REQ-018 ras_mispredict  out  1  one-cycle pulse on a RETURN mismatch.
REQ-019 ras_empty / ras_full  out  1 each  stack occupancy flags.

Function
REQ-020 pc_op encodings SHALL be: SEQ=0, BRANCH=1, JUMP=2, JUMP_REG=3, CALL=4, CALL_REG=5, RETURN=6, ERET=7.
REQ-021 Priority per edge SHALL be: reset > excp (incl. misalign) > stall > pc_op.
REQ-022 next_pc SHALL equal pc+4, modulo 2^XLEN.
REQ-023 Branch target SHALL equal next_pc + (sign-extended imm16 << 2), modulo 2^XLEN.
REQ-024 Jump target SHALL equal {pc[XLEN-1:28], jaddr, 2'b00}.
REQ-025 SEQ: pc <= next_pc; BRANCH: pc <= cond ? branch target : next_pc.
REQ-026 JUMP: pc <= jump target; CALL: same, plus push next_pc.
REQ-027 JUMP_REG: pc <= reg_target; CALL_REG: same, plus push next_pc.
REQ-028 RETURN: pc <= reg_target (authoritative) and pop one entry.
REQ-029 On RETURN, ras_mispredict SHALL pulse the following cycle if the stack was empty or the top entry != reg_target.
REQ-030 Push when full SHALL overwrite the oldest entry (circular); count saturates at RAS_DEPTH.
REQ-031 Pop when empty SHALL leave count 0.
REQ-032 ERET: pc <= epc; stack untouched.
REQ-033 Exception: epc <= pc, pc <= EXCP_ADRS, no push/pop; the stack is retained.
REQ-034 JUMP_REG/CALL_REG/RETURN with reg_target[1:0]!=0 SHALL be treated as an exception (REQ-033), with no push/pop.
REQ-035 Stall SHALL hold pc, epc and stack unchanged; ras_mispredict SHALL be 0.

Reset
REQ-036 On reset: pc=START_ADRS, epc=0, stack count=0, ras_empty=1, ras_full=0, ras_mispredict=0, ras_top=0.
REQ-037 Reset asserted mid-operation SHALL discard any pending push/pop, with no partial state update.

Structure
REQ-038 pc_pkg SHALL hold pc_op_t and the default START_ADRS/EXCP_ADRS constants.
REQ-039 The RAS SHALL be a sub-module ras_stack (parameters XLEN and RAS_DEPTH; push/pop/top/count).
REQ-040 Target arithmetic SHALL remain combinational in pc_sequencer.

Verification
REQ-041 Reset, then 3x SEQ -> pc = 0, 4, 8, 'hC.
REQ-042 pc='h100, BRANCH, imm16='hFFFF, cond=1 -> pc='h100; same with cond=0 -> pc='h104.
REQ-043 pc='h200, CALL jaddr='h40 -> pc='h100, ras_top='h204; then RETURN reg_target='h204 -> pc='h204, no mispredict, ras_empty=1.
REQ-044 Five CALLs with RAS_DEPTH=4 -> ras_full=1; five RETURNs with matching targets -> first four show no mispredict, fifth pulses ras_mispredict.
REQ-045 pc='h300, excp=1 with stall=1 -> pc='h80, epc='h300; then ERET -> pc='h300.
REQ-046 JUMP_REG reg_target='h402 -> pc='h80, epc=old pc; stall held 3 cycles -> pc constant.
